// File: rtl/bcd_mmss_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mmss_timer_pkg
// Brief    : Shared BCD types, constants and helpers for the MM:SS timer.
// Revision : 1.0
// ============================================================================
package bcd_mmss_timer_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  localparam bcd_pair_t BCD_ZERO = 8'h00;
  localparam bcd_pair_t SEC_MAX  = 8'h59;

  function automatic bcd_pair_t int_to_bcd2(input int unsigned v);
    int unsigned t;
    int unsigned u;
    t = (v / 10) % 10;
    u = v % 10;
    return {t[3:0], u[3:0]};
  endfunction

  function automatic bcd_digit_t bcd_sat_digit(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mmss_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mmss_timer_if
// Brief    : Control and display bundle between the panel logic and the timer.
// Revision : 1.0
// ============================================================================
interface bcd_mmss_timer_if;
  import bcd_mmss_timer_pkg::*;

  logic      run;
  logic      mode_down;
  logic      load;
  bcd_pair_t preset_min;
  bcd_pair_t preset_sec;
  bcd_pair_t timer_min;
  bcd_pair_t timer_sec;
  logic      sec_tick;
  logic      expired;
  logic      wrapped;
  logic      active;

  modport master (
    output run, mode_down, load, preset_min, preset_sec,
    input  timer_min, timer_sec, sec_tick, expired, wrapped, active
  );

  modport slave (
    input  run, mode_down, load, preset_min, preset_sec,
    output timer_min, timer_sec, sec_tick, expired, wrapped, active
  );

endinterface
`default_nettype wire

// File: rtl/bcd_mmss_timer_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_ctr
// Brief    : Single BCD digit up/down counter wrapping at LIMIT, with load.
// Revision : 1.0
// ============================================================================
module bcd_digit_ctr
  import bcd_mmss_timer_pkg::*;
#(
  parameter int LIMIT = 9
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       en_i,
  input  wire logic       down_i,
  input  wire logic       load_i,
  input  wire bcd_digit_t d_i,
  output bcd_digit_t      q_o,
  output logic            co_o
);

  localparam bcd_digit_t C_LIMIT = bcd_digit_t'(LIMIT);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      if (down_i) q_d = (q_q == 4'd0)    ? C_LIMIT : q_q - 4'd1;
      else        q_d = (q_q == C_LIMIT) ? 4'd0    : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

  // Carry (up) or borrow (down) into the next digit on this step
  assign co_o = en_i && !load_i && (down_i ? (q_q == 4'd0) : (q_q == C_LIMIT));
  assign q_o  = q_q;

endmodule
`default_nettype wire

// File: rtl/bcd_mmss_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mmss_timer
// Brief    : Prescaled BCD MM:SS up/down timer with preset load and pulses.
// Revision : 1.0
// ============================================================================
module bcd_mmss_timer
  import bcd_mmss_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 59
) (
  input  wire logic        CLOCK_50,
  input  wire logic        myreset,
  bcd_mmss_timer_if.slave  tif
);

  localparam int             DIV         = CLK_HZ / TICK_HZ;
  localparam int             PW          = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST  = PW'(DIV - 1);
  localparam bcd_pair_t      MAX_MIN_BCD = int_to_bcd2(MAX_MIN);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          sec_tick_q;
  logic          expired_q;
  logic          wrapped_q;

  bcd_digit_t su_q, st_q, mu_q, mt_q;
  logic       su_co, st_co, mu_co, mt_co;

  bcd_pair_t  w_min, w_sec;
  bcd_pair_t  w_pmin_raw, w_psec_raw, w_pmin, w_psec;
  logic       w_zero, w_enable, w_step, w_wrap, w_expire, w_dload;
  logic [15:0] w_dval;

  assign w_min    = {mt_q, mu_q};
  assign w_sec    = {st_q, su_q};
  assign w_zero   = (w_min == BCD_ZERO) && (w_sec == BCD_ZERO);
  assign w_enable = tif.run && !(tif.mode_down && w_zero);
  assign w_step   = w_enable && (presc_q == PRESC_LAST) && !tif.load;
  assign w_wrap   = w_step && !tif.mode_down && (w_min == MAX_MIN_BCD) && (w_sec == SEC_MAX);
  assign w_expire = w_step && tif.mode_down && (w_min == BCD_ZERO) && (w_sec == 8'h01);

  // Valid packed BCD compares correctly as a plain binary number
  assign w_pmin_raw = {bcd_sat_digit(tif.preset_min[7:4]), bcd_sat_digit(tif.preset_min[3:0])};
  assign w_psec_raw = {bcd_sat_digit(tif.preset_sec[7:4]), bcd_sat_digit(tif.preset_sec[3:0])};
  assign w_pmin     = (w_pmin_raw > MAX_MIN_BCD) ? MAX_MIN_BCD : w_pmin_raw;
  assign w_psec     = (w_psec_raw[7:4] > 4'd5) ? SEC_MAX : w_psec_raw;

  // Wrap reuses the digit load path to force 00:00 past MAX_MIN:59
  assign w_dload = tif.load || w_wrap;
  assign w_dval  = tif.load ? {w_pmin, w_psec} : 16'h0000;

  bcd_digit_ctr #(.LIMIT(9)) u_sec_units (
    .clk(CLOCK_50), .rst(myreset), .en_i(w_step && !w_wrap), .down_i(tif.mode_down),
    .load_i(w_dload), .d_i(w_dval[3:0]), .q_o(su_q), .co_o(su_co)
  );

  bcd_digit_ctr #(.LIMIT(5)) u_sec_tens (
    .clk(CLOCK_50), .rst(myreset), .en_i(su_co), .down_i(tif.mode_down),
    .load_i(w_dload), .d_i(w_dval[7:4]), .q_o(st_q), .co_o(st_co)
  );

  bcd_digit_ctr #(.LIMIT(9)) u_min_units (
    .clk(CLOCK_50), .rst(myreset), .en_i(st_co), .down_i(tif.mode_down),
    .load_i(w_dload), .d_i(w_dval[11:8]), .q_o(mu_q), .co_o(mu_co)
  );

  bcd_digit_ctr #(.LIMIT(9)) u_min_tens (
    .clk(CLOCK_50), .rst(myreset), .en_i(mu_co), .down_i(tif.mode_down),
    .load_i(w_dload), .d_i(w_dval[15:12]), .q_o(mt_q), .co_o(mt_co)
  );

  always_comb begin
    presc_d = presc_q;
    if (tif.load)       presc_d = '0;
    else if (w_enable)  presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (myreset) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      expired_q  <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= w_step;
      expired_q  <= w_expire;
      wrapped_q  <= w_wrap;
    end
  end

  logic w_unused;
  assign w_unused = mt_co;

  assign tif.timer_min = w_min;
  assign tif.timer_sec = w_sec;
  assign tif.sec_tick  = sec_tick_q;
  assign tif.expired   = expired_q;
  assign tif.wrapped   = wrapped_q;
  assign tif.active    = w_enable;

endmodule
`default_nettype wire

// File: doc/bcd_mmss_timer.md
Name: bcd_mmss_timer

Overview:
Parametrised BCD minutes:seconds timer for the synthesizer front panel and 7-segment display path. It divides the system clock down to a configurable tick rate and counts up or down in packed BCD MM:SS. It supports run/pause, a synchronous preset load, countdown expiry and count-up wrap pulses. It replaces the fixed 00–59 seconds-only display timer and feeds the HEX display drivers and the sequencer.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ, must divide exactly and be >= 2
MAX_MIN, 59, highest minute value (integer 0..99); count-up wraps after MAX_MIN:59

Ports:
CLOCK_50  in  1  system clock
myreset  in  1  synchronous reset, active-high
run  in  1  level; 1 = count, 0 = pause (prescaler holds)
mode_down  in  1  0 = count up, 1 = count down
load  in  1  one-cycle strobe; load preset values
preset_min  in  8  packed BCD minutes
preset_sec  in  8  packed BCD seconds
timer_min  out  8  packed BCD minutes
timer_sec  out  8  packed BCD seconds
sec_tick  out  1  one-cycle pulse on every applied count step
expired  out  1  one-cycle pulse when a down-count reaches 00:00
wrapped  out  1  one-cycle pulse when an up-count wraps MAX_MIN:59 -> 00:00
active  out  1  1 when run=1 and not held at 00:00 in down mode

Behaviour:
- Reset is synchronous and active-high on CLOCK_50; all state is updated on posedge CLOCK_50 only.
- Reset (myreset=1) sets timer_min=8'h00, timer_sec=8'h00, prescaler=0, and all pulses to 0. active follows its combinational definition from the reset state.
- Priority per cycle: myreset > load > count step.
- Prescaler: counter width $clog2(DIV).
  - Increments only while counting is enabled.
  - step = enabled && prescaler==DIV-1; on step, prescaler returns to 0.
  - While paused the prescaler holds, so a pause keeps the fractional period.
- Enable: run && !(mode_down && value==00:00).
- Load:
  - Writes the preset and clears the prescaler; no tick is applied that cycle.
  - Sanitising: any BCD digit >9 is clamped to 9; sec tens >5 is clamped to 59.
  - A minute value above MAX_MIN is clamped to MAX_MIN (in BCD).
  - The first step after a load occurs DIV enabled cycles later.
- Up step:
  - sec units +1; 9 -> 0 with a carry to tens; sec tens 5 with carry -> 0 and minute +1 (BCD, units 9 -> 0 with tens carry).
  - From MAX_MIN:59, the next value is 00:00 and wrapped=1 for that cycle.
- Down step:
  - sec 00 -> 59 with a borrow from minutes (BCD borrow: units 0 -> 9).
  - A step from 00:01 gives 00:00 and expired=1 for the same cycle.
  - The timer then holds at 00:00: active=0, prescaler frozen, no further expired pulse.
  - Loading a nonzero preset or switching to up mode re-enables counting.
- sec_tick=1 on each cycle where a step is applied, registered together with the new value.
- Outputs are registered and change on the same edge as sec_tick; latency from a step condition to the outputs is 1 clock.
- Changing mode_down mid-period affects only the next step; the prescaler is not cleared.
- Asserting myreset mid-count abandons the current period.
- Value invariant: timer_sec is always valid BCD in 00..59 and timer_min in 00..MAX_MIN.

Decomposition:
- Shared package holds:
  - BCD digit type (4 bits) and packed pair type (8 bits)
  - constants BCD_ZERO=8'h00 and SEC_MAX=8'h59
  - function int_to_bcd2 (used to derive the BCD form of MAX_MIN at elaboration)
- One sub-module: bcd_digit_ctr. Parameter LIMIT (9 or 5). Ports: en, down, load, d, q, carry/borrow out.
- Four instances are chained: sec units, sec tens, min units, min tens. Minute-wrap and clamp logic sits in the top level.

Test Plan:
1. CLK_HZ=10, TICK_HZ=1, MAX_MIN=2; reset, run=1, up -> sec_tick every 10 clocks; 00:09 -> 00:10; 00:59 -> 01:00; 02:59 -> 00:00 with wrapped=1 for 1 cycle.
2. Load 01:00, mode_down=1, run=1 -> 00:59 after 10 clocks; continue to 00:00 with expired=1 exactly once, active=0, and the value held for 50 further clocks.
3. Pause: run=1 for 15 clocks, then run=0 for 100 clocks, then run=1 -> the next step arrives 5 clocks after resume; the value is unchanged during the pause.
4. Load sanitising: preset 8'h7A:8'h9F with MAX_MIN=59 -> timer reads 59:59. Load and step in the same cycle -> load wins; sec_tick=0 that cycle.
5. myreset asserted mid-period while load=1 -> 00:00, prescaler 0, no pulses; first step 10 clocks after release.
6. Default parameters (DIV=50,000,000) smoke test: one step after exactly 50,000,000 enabled clocks.
